// File: rtl/com_mem_frame_writer.sv
// com_mem_frame_writer
// Packs a sop/eop-delimited byte stream into 32-bit little-endian words and
// writes them into a ring of fixed-size slots in com_mem (second write port).
// Payload goes to slot words 1..SLOT_WORDS-1; the header (word 0) is written
// last to commit the frame, then wr_ptr advances and frame_irq pulses.
// Optional feature macro: COM_MEM_WRITER_STATS_EN (live drop/trunc counters).
module com_mem_frame_writer #(
  parameter int BASE_ADDR  = 512,
  parameter int SLOT_WORDS = 64,
  parameter int N_SLOTS    = 8,
  localparam int PW = $clog2(N_SLOTS) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_sop,
  input  logic          in_eop,
  output logic [9:0]    mem_address,
  output logic [3:0]    mem_byteenable,
  output logic          mem_chipselect,
  output logic          mem_write,
  output logic [31:0]   mem_writedata,
  input  logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] wr_ptr,
  output logic          frame_irq,
  output logic [15:0]   drop_count,
  output logic [15:0]   trunc_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_HDR  = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  localparam logic [15:0]   CAP       = 16'((SLOT_WORDS - 1) * 4);
  localparam logic [PW-1:0] RING_FULL = PW'(N_SLOTS);

  logic [2:0]  state;
  logic [2:0]  nxt_state;
  logic [1:0]  lane;        // next byte lane to fill
  logic [23:0] acc;         // lanes 0..2 of the word being assembled
  logic [9:0]  word_idx;    // payload word index within the slot
  logic [15:0] byte_len;    // saturates at CAP
  logic        trunc;
  logic [7:0]  seq;

  logic        beat;
  logic        ring_full;
  logic        room;
  logic        take_byte;
  logic [9:0]  slot_base;
  logic [31:0] merged;
  logic [3:0]  lane_be;

  // Handshake, ring occupancy and the word formed by merging the current byte
  always_comb begin
    beat      = in_valid & in_ready;
    ring_full = ((wr_ptr - rd_ptr) == RING_FULL);
    room      = (byte_len < CAP);
    take_byte = beat && (((state == S_IDLE) && in_sop && !ring_full) ||
                         (state == S_FILL));
    slot_base = 10'(BASE_ADDR + int'(wr_ptr[PW-2:0]) * SLOT_WORDS);
    merged    = {8'h00, acc};
    merged[{lane, 3'b000} +: 8] = in_data;
    case (lane)
      2'd0:    lane_be = 4'b0001;
      2'd1:    lane_be = 4'b0011;
      2'd2:    lane_be = 4'b0111;
      default: lane_be = 4'b1111;
    endcase
  end

  // Frame state sequencing
  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE: begin
        if (beat && in_sop) begin
          if (ring_full) nxt_state = in_eop ? S_IDLE : S_DROP;
          else           nxt_state = in_eop ? S_LAST : S_FILL;
        end
      end
      S_FILL:  if (beat && in_eop) nxt_state = S_LAST;
      S_LAST:  nxt_state = S_HDR;
      S_HDR:   nxt_state = S_IDLE;
      S_DROP:  if (beat && in_eop) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Datapath: byte packing, registered memory writes, header commit
  // A frame's final partial word is issued on the eop beat itself, so it
  // occupies the LAST cycle; LAST then issues the header, seen during HDR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      in_ready       <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      wr_ptr         <= '0;
      frame_irq      <= 1'b0;
      lane           <= '0;
      acc            <= '0;
      word_idx       <= '0;
      byte_len       <= '0;
      trunc          <= 1'b0;
      seq            <= '0;
    end else begin
      state          <= nxt_state;
      in_ready       <= (nxt_state == S_IDLE) || (nxt_state == S_FILL) ||
                        (nxt_state == S_DROP);
      mem_write      <= 1'b0;
      mem_chipselect <= 1'b0;
      frame_irq      <= 1'b0;

      if (take_byte) begin
        if (room) begin
          byte_len <= byte_len + 16'd1;
          lane     <= lane + 2'd1;
          if (lane == 2'd3) begin
            acc      <= '0;
            word_idx <= word_idx + 10'd1;
          end else begin
            acc <= merged[23:0];
          end
          if ((lane == 2'd3) || in_eop) begin
            mem_write      <= 1'b1;
            mem_chipselect <= 1'b1;
            mem_address    <= slot_base + 10'd1 + word_idx;
            mem_byteenable <= lane_be;
            mem_writedata  <= merged;
          end
        end else begin
          trunc <= 1'b1;
        end
      end

      if (state == S_LAST) begin
        mem_write      <= 1'b1;
        mem_chipselect <= 1'b1;
        mem_address    <= slot_base;
        mem_byteenable <= 4'hF;
        mem_writedata  <= {6'b0, trunc, 1'b1, seq, byte_len};
        wr_ptr         <= wr_ptr + PW'(1);
        seq            <= seq + 8'd1;
        frame_irq      <= 1'b1;
      end

      if (state == S_HDR) begin
        lane     <= '0;
        acc      <= '0;
        word_idx <= '0;
        byte_len <= '0;
        trunc    <= 1'b0;
      end
    end
  end

`ifdef COM_MEM_WRITER_STATS_EN
  logic drop_evt;
  logic trunc_evt;

  assign drop_evt  = beat && in_eop &&
                     (((state == S_IDLE) && in_sop && ring_full) || (state == S_DROP));
  assign trunc_evt = (state == S_HDR) && trunc;

  // Saturating statistics counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count  <= '0;
      trunc_count <= '0;
    end else begin
      if (drop_evt && (drop_count != 16'hFFFF))   drop_count  <= drop_count + 16'd1;
      if (trunc_evt && (trunc_count != 16'hFFFF)) trunc_count <= trunc_count + 16'd1;
    end
  end
`else
  assign drop_count  = '0;
  assign trunc_count = '0;
`endif

endmodule

// File: tb/tb_com_mem_frame_writer.sv
// Directed self-checking bench for com_mem_frame_writer (default parameters).
module tb_com_mem_frame_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  rd_ptr = 4'd0;
  logic [3:0]  wr_ptr;
  logic        frame_irq;
  logic [15:0] drop_count;
  logic [15:0] trunc_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned eop_cyc = 0;

  logic [31:0] wa[$];
  logic [31:0] wb[$];
  logic [31:0] wd[$];
  int unsigned wc[$];
  int unsigned irq_n = 0;
  int unsigned irq_c = 0;
  int unsigned cs_bad = 0;

  com_mem_frame_writer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .frame_irq(frame_irq),
    .drop_count(drop_count), .trunc_count(trunc_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_write) begin
      wa.push_back(32'(mem_address));
      wb.push_back(32'(mem_byteenable));
      wd.push_back(mem_writedata);
      wc.push_back(cyc);
      if (!mem_chipselect) cs_bad <= cs_bad + 1;
    end
    if (frame_irq) begin
      irq_n <= irq_n + 1;
      irq_c <= cyc;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ga(int unsigned i);
    return (i < wa.size()) ? wa[i] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] gb(int unsigned i);
    return (i < wb.size()) ? wb[i] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] gd(int unsigned i);
    return (i < wd.size()) ? wd[i] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] gc(int unsigned i);
    return (i < wc.size()) ? 32'(wc[i]) : 32'hFFFF_FFFF;
  endfunction

  // Called at a negedge; returns at the following negedge after the beat.
  task automatic put(input logic [7:0] d, input logic s, input logic e);
    int unsigned n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("put_ready_timeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
    if (e) eop_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic frame(input int unsigned len, input logic [7:0] start);
    for (int unsigned i = 0; i < len; i++)
      put(8'(start + 8'(i)), i == 0, i == len - 1);
  endtask

  task automatic settle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wa.delete(); wb.delete(); wd.delete(); wc.delete();
    irq_n = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; rd_ptr = 4'd0;
    settle(2);
    reset = 1'b0;
    settle(1);
    clear_log();
  endtask

  logic [15:0] exp_drop2;
  logic [15:0] exp_trunc1;
  int unsigned bad;

  initial begin
`ifdef COM_MEM_WRITER_STATS_EN
    exp_drop2  = 16'd2;
    exp_trunc1 = 16'd1;
`else
    exp_drop2  = 16'd0;
    exp_trunc1 = 16'd0;
`endif

    // Reset state
    settle(2);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_irq", {31'b0, frame_irq}, 32'd0);
    chk("rst_counts", {drop_count, trunc_count}, 32'd0);
    reset = 1'b0;
    settle(1);
    chk("rst_ready_rise", {31'b0, in_ready}, 32'd1);
    clear_log();

    // 5-byte frame
    put(8'h11, 1'b1, 1'b0); put(8'h22, 1'b0, 1'b0); put(8'h33, 1'b0, 1'b0);
    put(8'h44, 1'b0, 1'b0); put(8'h55, 1'b0, 1'b1);
    chk("f5_ready_t1", {31'b0, in_ready}, 32'd0);
    settle(1);
    chk("f5_ready_t2", {31'b0, in_ready}, 32'd0);
    settle(1);
    chk("f5_ready_t3", {31'b0, in_ready}, 32'd1);
    settle(2);
    chk("f5_nwrites", 32'(wa.size()), 32'd3);
    chk("f5_w0_addr", ga(0), 32'd513);
    chk("f5_w0_be", gb(0), 32'hF);
    chk("f5_w0_data", gd(0), 32'h44332211);
    chk("f5_w1_addr", ga(1), 32'd514);
    chk("f5_w1_be", gb(1), 32'h1);
    chk("f5_w1_data", gd(1), 32'h00000055);
    chk("f5_w1_cyc", gc(1), 32'(eop_cyc + 1));
    chk("f5_hdr_addr", ga(2), 32'd512);
    chk("f5_hdr_data", gd(2), 32'h01000005);
    chk("f5_hdr_cyc", gc(2), 32'(eop_cyc + 2));
    chk("f5_wr_ptr", 32'(wr_ptr), 32'd1);
    chk("f5_irq_n", 32'(irq_n), 32'd1);
    chk("f5_irq_cyc", 32'(irq_c), 32'(eop_cyc + 2));
    chk("f5_cs", 32'(cs_bad), 32'd0);

    // Ring full
    do_reset();
    for (int unsigned f = 0; f < 8; f++) frame(1, 8'(8'h10 + 8'(f)));
    settle(3);
    chk("ring_wr_ptr8", 32'(wr_ptr), 32'd8);
    chk("ring_nwrites8", 32'(wa.size()), 32'd16);
    clear_log();
    frame(3, 8'hC0);
    frame(1, 8'hD0);
    settle(3);
    chk("ring_drop_nowrite", 32'(wa.size()), 32'd0);
    chk("ring_drop_irq", 32'(irq_n), 32'd0);
    chk("ring_drop_count", 32'(drop_count), 32'(exp_drop2));
    chk("ring_wr_ptr_hold", 32'(wr_ptr), 32'd8);
    rd_ptr = 4'd1;
    frame(2, 8'h01);
    settle(3);
    chk("ring10_nwrites", 32'(wa.size()), 32'd2);
    chk("ring10_w0_addr", ga(0), 32'd513);
    chk("ring10_w0_be", gb(0), 32'h3);
    chk("ring10_w0_data", gd(0), 32'h00000201);
    chk("ring10_hdr_addr", ga(1), 32'd512);
    chk("ring10_hdr_data", gd(1), 32'h01080002);
    chk("ring10_wr_ptr", 32'(wr_ptr), 32'd9);

    // Oversized frame
    do_reset();
    frame(300, 8'h00);
    settle(3);
    chk("ovr_nwrites", 32'(wa.size()), 32'd64);
    bad = 0;
    for (int unsigned k = 0; k < 63; k++) begin
      if (ga(k) !== 32'(513 + k) || gb(k) !== 32'hF ||
          gd(k) !== {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)})
        bad++;
    end
    chk("ovr_payload_bad", 32'(bad), 32'd0);
    chk("ovr_last_data", gd(62), 32'hFBFAF9F8);
    chk("ovr_hdr_addr", ga(63), 32'd512);
    chk("ovr_hdr_data", gd(63), 32'h03000000 | 32'd252);
    chk("ovr_trunc_count", 32'(trunc_count), 32'(exp_trunc1));

    // Stray data and 1-byte frame
    do_reset();
    put(8'h01, 1'b0, 1'b0); put(8'h02, 1'b0, 1'b1); put(8'h03, 1'b0, 1'b0);
    settle(3);
    chk("stray_nowrite", 32'(wa.size()), 32'd0);
    put(8'hAB, 1'b1, 1'b1);
    settle(3);
    chk("one_nwrites", 32'(wa.size()), 32'd2);
    chk("one_w0_addr", ga(0), 32'd513);
    chk("one_w0_be", gb(0), 32'h1);
    chk("one_w0_data", gd(0), 32'h000000AB);
    chk("one_hdr_addr", ga(1), 32'd512);
    chk("one_hdr_data", gd(1), 32'h01000001);
    chk("one_hdr_cyc", gc(1), 32'(eop_cyc + 2));

    // Reset mid-frame
    do_reset();
    put(8'h61, 1'b1, 1'b0);
    for (int unsigned i = 1; i < 6; i++) put(8'(8'h61 + 8'(i)), 1'b0, 1'b0);
    chk("mid_pre_writes", 32'(wa.size()), 32'd1);
    reset = 1'b1;
    settle(2);
    chk("mid_rst_wr_ptr", 32'(wr_ptr), 32'd0);
    reset = 1'b0;
    settle(3);
    chk("mid_no_hdr", 32'(wa.size()), 32'd1);
    clear_log();
    frame(2, 8'h5A);
    settle(3);
    chk("mid_next_nwrites", 32'(wa.size()), 32'd2);
    chk("mid_next_w0", gd(0), 32'h00005B5A);
    chk("mid_next_hdr_addr", ga(1), 32'd512);
    chk("mid_next_hdr_data", gd(1), 32'h01000002);

    // Exact multiple of 4 (slot 1, seq 1)
    clear_log();
    frame(8, 8'h01);
    settle(3);
    chk("x4_nwrites", 32'(wa.size()), 32'd3);
    chk("x4_w0_addr", ga(0), 32'd577);
    chk("x4_w0_data", gd(0), 32'h04030201);
    chk("x4_w1_addr", ga(1), 32'd578);
    chk("x4_w1_data", gd(1), 32'h08070605);
    chk("x4_be_full", gb(0) & gb(1), 32'hF);
    chk("x4_hdr_addr", ga(2), 32'd576);
    chk("x4_hdr_data", gd(2), 32'h01010008);
    chk("x4_hdr_cyc", gc(2), 32'(eop_cyc + 2));
    chk("x4_wr_ptr", 32'(wr_ptr), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
